regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug readout engine that acts as the reader on the processor register file's read port. On a start pulse it walks registers 0..NUM_REGS-1 through one read port, snapshots each 32-bit word, and streams it out as bytes, most-significant byte first, over a valid/ready handshake. The byte stream feeds the robot's debug UART transmitter. The block uses an otherwise idle read-port address, so processor reads through the other port are undisturbed.

## Interface
- NUM_REGS, 32, number of registers dumped, starting at index 0
- ADDR_W, 5, register address width
- DATA_W, 32, register word width; must be a multiple of 8

- clock  in  1  single system clock, rising-edge
- ctrl_reset  in  1  reset; one clock, reset is synchronous and active-high
- start  in  1  one-cycle request to begin a dump; ignored while busy
- ctrl_readReg  out  ADDR_W  read-port address driven to the register file
- data_readReg  in  DATA_W  register file read data; combinational from ctrl_readReg
- out_data  out  8  current byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts the byte when out_valid && out_ready
- out_last  out  1  high with the final byte of the final register
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse when a dump completes

## Operation
- FSM states: IDLE, READ, SEND, DONE.
- IDLE: busy=0. On start, go to READ, reg_idx=0, byte_idx=0.
- READ (one cycle): ctrl_readReg=reg_idx. At the clock edge, latch data_readReg into word_buf. Go to SEND.
- SEND:
  - out_valid=1; out_data=word_buf[DATA_W-1-8*byte_idx -: 8], so byte 0 is the MSB.
  - On handshake: if byte_idx<DATA_W/8-1, then byte_idx++.
  - Otherwise byte_idx=0. If reg_idx==NUM_REGS-1, go to DONE. Else reg_idx++ and go to READ.
- DONE (one cycle): done=1, then IDLE.
- Hold rule: while out_valid && !out_ready, out_data, out_last, and all internal state hold. out_valid never drops without a handshake.
- out_last = SEND && reg_idx==NUM_REGS-1 && byte_idx==DATA_W/8-1.
- ctrl_readReg = reg_idx in READ and SEND, 0 in IDLE and DONE.
- Snapshot semantics: each register is sampled in its own READ cycle. A write to that register in the same cycle is not captured, because the register file returns the old value until the edge. A write in an earlier cycle is captured. The dump is not atomic across registers.
- start arriving in READ, SEND, or DONE is dropped; no queueing.
- Reset values: all outputs 0; state=IDLE; reg_idx=byte_idx=0; word_buf=0.
- Reset mid-dump aborts immediately. No done pulse, no partial flush.
- Counters: reg_idx is ADDR_W bits and never wraps past NUM_REGS-1. byte_idx is $clog2(DATA_W/8) bits.

## Timing
- start sampled high at edge N: READ during cycle N+1; first out_valid in cycle N+2.
- Per register: 1 READ cycle plus DATA_W/8 SEND cycles minimum. For the defaults that is 5 cycles, and a full dump takes at least 160 cycles from READ of reg 0 to the last handshake.
- done is high the cycle after the last handshake. busy is high from N+1 through the DONE cycle inclusive.
- A new start is accepted in the cycle after DONE, back-to-back.
- No combinational path from out_ready to out_valid or out_data.

## Structure
- Shared package regfile_dump_pkg holds:
  - state enum (IDLE, READ, SEND, DONE), 2-bit encoding
  - BYTES_PER_WORD = DATA_W/8
  - default NUM_REGS and ADDR_W constants, also used by regfile instantiation
- One sub-module is natural: word_serializer. It loads a word and emits BYTES_PER_WORD bytes MSB-first with valid/ready and last-byte flags. regfile_dump keeps the FSM and reg_idx.

## Test plan
- Preload reg k with 32'h0A0B0C00|k and reg 0 reads 0; start with out_ready tied 1 -> 128 bytes: 00,00,00,00, then 0A,0B,0C,01, and so on. out_last only on byte 128; done exactly 1 cycle after it; total 160 cycles.
- Random out_ready backpressure, about 30% stall -> byte sequence identical to the first test; out_data is stable on every stalled cycle.
- Pulse start again at byte 50 -> ignored, single dump, one done pulse. start in the cycle after done -> second dump begins.
- Write reg 5 = 32'hDEADBEEF in the same cycle as its READ -> old value dumped. Write one cycle earlier -> DE,AD,BE,EF dumped.
- Assert ctrl_reset during reg 17 byte 2 -> next cycle all outputs 0 and state IDLE, with no done. A later start dumps from reg 0.
- ctrl_readReg trace equals 0..31 in order, and is 0 while idle.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared constants and state encoding for the register-file dump engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_dump_pkg;

   localparam int NUM_REGS_DEF   = 32;
   localparam int ADDR_W_DEF     = 5;
   localparam int DATA_W_DEF     = 32;
   localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

   // Dump FSM encoding, kept as plain 2-bit constants for legacy tools
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_READ = 2'd1;
   localparam state_t S_SEND = 2'd2;
   localparam state_t S_DONE = 2'd3;

   // Width of a byte counter for a word of bpw bytes (at least one bit)
   function automatic int byte_idx_w(input int bpw);
      return (bpw > 1) ? $clog2(bpw) : 1;
   endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Byte stream from the dump engine toward the debug UART transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: byte transfers when out_valid && out_ready.
interface regfile_dump_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/regfile_dump_word_serializer.sv
// Loads one register word and emits its bytes MSB first on a valid/ready stream.
// Latency: first byte valid the cycle after load, one byte per accepted cycle.
// Backpressure: word, byte index and valid hold while out_valid && !out_ready.
module regfile_dump_word_serializer
   import regfile_dump_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              ctrl_reset,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_word,
   input  logic              i_last_word,
   regfile_dump_if.master    o_byte,
   output logic              o_word_done
);

   localparam int BPW = DATA_W / 8;
   localparam int BIW = byte_idx_w(BPW);
   localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW - 1);

   logic [DATA_W-1:0] r_word;
   logic [BIW-1:0]    r_byte_idx;
   logic              r_vld;
   logic              w_fire;
   logic              w_last_byte;

   // The word is shifted left after each accepted byte, so the top byte is always current
   assign w_fire          = r_vld & o_byte.out_ready;
   assign w_last_byte     = (r_byte_idx == LAST_BYTE);
   assign o_byte.out_valid = r_vld;
   assign o_byte.out_data  = r_word[DATA_W-1 -: 8];
   assign o_byte.out_last  = r_vld & i_last_word & w_last_byte;
   assign o_word_done      = w_fire & w_last_byte;

   // Snapshot on load, advance one byte per handshake, drop valid after the final byte
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         r_word     <= '0;
         r_byte_idx <= '0;
         r_vld      <= 1'b0;
      end else if (i_load) begin
         r_word     <= i_word;
         r_byte_idx <= '0;
         r_vld      <= 1'b1;
      end else if (w_fire) begin
         r_word <= r_word << 8;
         if (w_last_byte) begin
            r_byte_idx <= '0;
            r_vld      <= 1'b0;
         end else begin
            r_byte_idx <= r_byte_idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_dump.sv
// Walks register file entries 0..NUM_REGS-1 through a spare read port and streams them as bytes.
// Latency: start at edge N -> READ in N+1, first byte valid in N+2; 1+DATA_W/8 cycles per register unstalled.
// Backpressure: out_ready low freezes the stream and the walk; out_valid never drops without a handshake.
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              ctrl_reset,
   input  logic              start,
   output logic [ADDR_W-1:0] ctrl_readReg,
   input  logic [DATA_W-1:0] data_readReg,
   regfile_dump_if.master    out_if,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_reg_idx;
   logic              w_word_done;
   logic              w_last_reg;
   logic              w_load;

   assign w_last_reg   = (r_reg_idx == LAST_REG);
   assign w_load       = (r_state == S_READ);
   assign ctrl_readReg = (r_state == S_READ || r_state == S_SEND) ? r_reg_idx : '0;
   assign busy         = (r_state != S_IDLE);
   assign done         = (r_state == S_DONE);

   // The register word is captured at the edge that ends the READ cycle
   regfile_dump_word_serializer #(
      .DATA_W (DATA_W)
   ) u_ser (
      .clock       (clock),
      .ctrl_reset  (ctrl_reset),
      .i_load      (w_load),
      .i_word      (data_readReg),
      .i_last_word (w_last_reg),
      .o_byte      (out_if),
      .o_word_done (w_word_done)
   );

   // Dump sequencer: one READ per register, SEND until its last byte is accepted, then next or DONE
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         r_state   <= S_IDLE;
         r_reg_idx <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_READ;
                  r_reg_idx <= '0;
               end
            end
            S_READ: begin
               r_state <= S_SEND;
            end
            S_SEND: begin
               if (w_word_done) begin
                  if (w_last_reg) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state   <= S_READ;
                     r_reg_idx <= r_reg_idx + 1'b1;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_reg_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump with a register-file model and a stream-level reference.
// Latency: n/a.
// Backpressure: out_ready driven from a random stall percentage.
module tb_regfile_dump;
   import regfile_dump_pkg::*;

   localparam int NR = NUM_REGS_DEF;
   localparam int AW = ADDR_W_DEF;
   localparam int DW = DATA_W_DEF;
   localparam int NBYTES = NR * (DW / 8);

   logic          clock = 1'b0;
   logic          ctrl_reset;
   logic          start;
   logic [AW-1:0] ctrl_readReg;
   logic [DW-1:0] data_readReg;
   logic          busy;
   logic          done;

   regfile_dump_if u_if ();

   regfile_dump #(
      .NUM_REGS (NR),
      .ADDR_W   (AW),
      .DATA_W   (DW)
   ) dut (
      .clock        (clock),
      .ctrl_reset   (ctrl_reset),
      .start        (start),
      .ctrl_readReg (ctrl_readReg),
      .data_readReg (data_readReg),
      .out_if       (u_if),
      .busy         (busy),
      .done         (done)
   );

   always #5 clock = ~clock;

   // Register file: combinational read, write commits at the clock edge
   logic [DW-1:0] regs [NR];
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   always @(posedge clock) if (wr_en) regs[wr_addr] <= wr_data;
   assign data_readReg = regs[ctrl_readReg];

   logic [DW-1:0] model_regs [NR];
   logic [DW-1:0] snap [NR];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int stall_pct = 0;

   logic [7:0]    got_q [$];
   logic [7:0]    exp_q [$];
   logic [AW-1:0] trace_q [$];
   int last_cnt, last_pos, done_cnt, done_cyc, last_cyc, start_cyc;
   int stall_bad, n_stall, rr_bad, idle_bad;
   logic prev_stall;
   logic [7:0] prev_data;
   logic prev_last;
   logic rst_hit;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe at the falling edge, then advance past the rising edge
   task automatic tick();
      int idx;
      @(negedge clock);
      if (u_if.out_valid && u_if.out_ready) begin
         got_q.push_back(u_if.out_data);
         idx = got_q.size() - 1;
         if (u_if.out_last) begin
            last_cnt++;
            last_pos = got_q.size();
         end
         last_cyc = cyc;
         if (int'(ctrl_readReg) != idx / (DW / 8)) rr_bad++;
      end
      if (prev_stall) begin
         n_stall++;
         if (!u_if.out_valid || u_if.out_data !== prev_data || u_if.out_last !== prev_last) stall_bad++;
      end
      prev_stall = u_if.out_valid && !u_if.out_ready;
      prev_data  = u_if.out_data;
      prev_last  = u_if.out_last;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) begin
         if (trace_q.size() == 0 || trace_q[$] != ctrl_readReg) trace_q.push_back(ctrl_readReg);
      end else if (ctrl_readReg != '0) begin
         idle_bad++;
      end
      @(posedge clock);
      #1;
      cyc++;
      u_if.out_ready = ($urandom_range(99) >= stall_pct);
   endtask

   task automatic wr_reg(input int a, input logic [DW-1:0] v);
      wr_addr = AW'(a);
      wr_data = v;
      wr_en   = 1'b1;
      tick();
      wr_en = 1'b0;
      model_regs[a] = v;
   endtask

   // Runs one dump. A write issued wr_off cycles after the start edge commits at the
   // following edge; with the sink always ready, register r is read in cycle 5r, so the
   // write is seen only if it commits no later than that cycle begins.
   task automatic run_dump(input int spct, input int wr_off, input int wa, input logic [DW-1:0] wv,
                           input int restart_byte, input int rst_off);
      int k;
      int guard;
      bit restarted;
      stall_pct = spct;
      got_q.delete(); exp_q.delete(); trace_q.delete();
      last_cnt = 0; last_pos = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
      stall_bad = 0; n_stall = 0; rr_bad = 0; idle_bad = 0;
      prev_stall = 1'b0; rst_hit = 1'b0; restarted = 1'b0;
      for (int r = 0; r < NR; r++) snap[r] = model_regs[r];
      if (wr_off >= 0 && wr_off + 1 <= 5 * wa) snap[wa] = wv;
      for (int r = 0; r < NR; r++)
         for (int b = 0; b < DW / 8; b++)
            exp_q.push_back(8'((snap[r] >> (DW - 8 - 8 * b)) & 32'hFF));
      start = 1'b1;
      tick();
      start = 1'b0;
      start_cyc = cyc;
      guard = 0;
      while (done_cnt == 0 && guard < 4000 && !rst_hit) begin
         k = cyc - start_cyc;
         wr_en   = (k == wr_off);
         wr_addr = AW'(wa);
         wr_data = wv;
         if (restart_byte >= 0 && !restarted && got_q.size() == restart_byte) begin
            start = 1'b1;
            restarted = 1'b1;
         end
         if (k == rst_off) ctrl_reset = 1'b1;
         tick();
         wr_en = 1'b0;
         start = 1'b0;
         if (ctrl_reset) begin
            ctrl_reset = 1'b0;
            rst_hit = 1'b1;
         end
         guard++;
      end
      if (wr_off >= 0) model_regs[wa] = wv;
      check_eq("dump_finished", (done_cnt == 0 && !rst_hit), 0);
   endtask

   task automatic check_dump(input string tag);
      int nbad;
      nbad = 0;
      check_eq({tag, " nbytes"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) nbad++;
      check_eq({tag, " byte_mismatches"}, nbad, 0);
      check_eq({tag, " last_count"}, last_cnt, 1);
      check_eq({tag, " last_position"}, last_pos, NBYTES);
      check_eq({tag, " done_pulses"}, done_cnt, 1);
      check_eq({tag, " done_after_last"}, done_cyc - last_cyc, 1);
      check_eq({tag, " dump_cycles"}, done_cyc - start_cyc, NR * (1 + DW / 8) + n_stall);
      check_eq({tag, " stall_hold_bad"}, stall_bad, 0);
      check_eq({tag, " readreg_per_byte_bad"}, rr_bad, 0);
      check_eq({tag, " idle_readreg_bad"}, idle_bad, 0);
      nbad = 0;
      if (trace_q.size() != NR + 1) nbad++;
      for (int i = 0; i < trace_q.size() && i < NR + 1; i++)
         if (int'(trace_q[i]) != ((i < NR) ? i : 0)) nbad++;
      check_eq({tag, " readreg_trace_bad"}, nbad, 0);
   endtask

   function automatic logic [31:0] got_word(input int r);
      int b0;
      b0 = r * 4;
      if (got_q.size() < b0 + 4) return 32'h0;
      return {got_q[b0], got_q[b0 + 1], got_q[b0 + 2], got_q[b0 + 3]};
   endfunction

   initial begin
      int prev_done;
      ctrl_reset = 1'b1; start = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      u_if.out_ready = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_eq("rst out_valid", u_if.out_valid, 0);
      check_eq("rst out_data", u_if.out_data, 0);
      check_eq("rst out_last", u_if.out_last, 0);
      check_eq("rst busy", busy, 0);
      check_eq("rst done", done, 0);
      check_eq("rst readReg", ctrl_readReg, 0);
      @(posedge clock);
      #1;
      ctrl_reset = 1'b0;

      for (int r = 0; r < NR; r++) wr_reg(r, (r == 0) ? 32'h0 : (32'h0A0B0C00 | r));

      // Sink always ready
      run_dump(0, -1, 0, 0, -1, -1);
      check_dump("plain");
      check_eq("plain reg1_word", got_word(1), 32'h0A0B0C01);

      // Random stalls around 30%
      run_dump(30, -1, 0, 0, -1, -1);
      check_dump("stall");
      check_eq("stall stalls_seen", (n_stall > 0), 1);

      // Start during SEND is dropped; start right after DONE begins a new dump
      run_dump(0, -1, 0, 0, 50, -1);
      check_dump("restart_ignored");
      prev_done = done_cyc;
      run_dump(0, -1, 0, 0, -1, -1);
      check_dump("back_to_back");
      check_eq("back_to_back start_cycle", start_cyc - prev_done, 2);
      done_cnt = 0;
      repeat (5) tick();
      check_eq("quiet done_pulses", done_cnt, 0);
      check_eq("quiet busy", busy, 0);

      // Write to reg 5 in its own READ cycle, then one cycle earlier
      run_dump(0, 25, 5, 32'hDEADBEEF, -1, -1);
      check_dump("write_same_cycle");
      check_eq("write_same_cycle reg5", got_word(5), 32'h0A0B0C05);
      wr_reg(5, 32'h0A0B0C05);
      run_dump(0, 24, 5, 32'hDEADBEEF, -1, -1);
      check_dump("write_earlier");
      check_eq("write_earlier reg5", got_word(5), 32'hDEADBEEF);

      // Reset while reg 17 byte 2 is on the bus
      run_dump(0, -1, 0, 0, -1, 17 * 5 + 3);
      check_eq("abort reset_applied", rst_hit, 1);
      check_eq("abort nbytes", got_q.size(), 17 * 4 + 3);
      @(negedge clock);
      check_eq("abort out_valid", u_if.out_valid, 0);
      check_eq("abort out_data", u_if.out_data, 0);
      check_eq("abort out_last", u_if.out_last, 0);
      check_eq("abort busy", busy, 0);
      check_eq("abort readReg", ctrl_readReg, 0);
      @(posedge clock);
      #1;
      cyc++;
      done_cnt = 0;
      repeat (10) tick();
      check_eq("abort done_pulses", done_cnt, 0);
      run_dump(20, -1, 0, 0, -1, -1);
      check_dump("after_abort");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
